// File: rtl/fifo_ctrl_v2_if.sv
// fifo_ctrl_v2_if -- handshake, data and status bundle for fifo_ctrl_v2.
//
// Producer side : w_valid, data_in
// Consumer side : r_ready, data_out, r_valid
// Status        : fifo_full, fifo_empty, almost_full, almost_empty, count
// Errors        : clr_err, overflow, underflow
//
// slave  modport : the FIFO itself.
// master modport : the stage(s) driving and consuming the FIFO.
interface fifo_ctrl_v2_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic             w_valid;
    logic [WIDTH-1:0] data_in;
    logic             r_ready;
    logic [WIDTH-1:0] data_out;
    logic             r_valid;
    logic             fifo_full;
    logic             fifo_empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             clr_err;
    logic             overflow;
    logic             underflow;

    modport slave (
        input  w_valid, data_in, r_ready, clr_err,
        output data_out, r_valid, fifo_full, fifo_empty,
               almost_full, almost_empty, count, overflow, underflow
    );

    modport master (
        output w_valid, data_in, r_ready, clr_err,
        input  data_out, r_valid, fifo_full, fifo_empty,
               almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl_v2.sv
// fifo_ctrl_v2 -- single-clock FIFO with arbitrary depth, occupancy count,
// programmable almost-full/almost-empty, FWFT or registered read, and
// sticky overflow/underflow flags.
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  asynchronous, active-low reset
//   bus    fifo_ctrl_v2_if.slave (write/read handshake, data, status, errors)
//
// Parameters: WIDTH, DEPTH (>= 2), AF_TH (1..DEPTH), AE_TH (0..DEPTH-1),
//             FWFT (1 = head visible without a read, 0 = 1-cycle read).
module fifo_ctrl_v2 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    parameter int AF_TH = DEPTH - 1,
    parameter int AE_TH = 1,
    parameter int FWFT  = 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    fifo_ctrl_v2_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_q, count_d;
    logic             fifo_full, fifo_empty;
    logic             wr_en, rd_en;
    logic             overflow_q, underflow_q;

    // Status flags decode the registered count, so they follow reset at once.
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // A write while full is dropped even if a read frees a slot this cycle.
    assign wr_en = bus.w_valid && !fifo_full;
    assign rd_en = bus.r_ready && !fifo_empty;

    assign bus.fifo_full    = fifo_full;
    assign bus.fifo_empty   = fifo_empty;
    assign bus.almost_full  = (count_q >= CW'(AF_TH));
    assign bus.almost_empty = (count_q <= CW'(AE_TH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            // Explicit wrap at DEPTH-1: depth need not be a power of two.
            if (wr_en) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            // Set has priority over clear when both happen in one cycle.
            if (bus.w_valid && fifo_full) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_q <= 1'b0;
            end
            if (bus.r_ready && fifo_empty) begin
                underflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers and count
    // define which entries are valid, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; forced to zero when nothing is stored
            // so a stale or never-written entry is never presented.
            assign bus.data_out = fifo_empty ? '0 : mem[rd_ptr];
            assign bus.r_valid  = !fifo_empty;
        end else begin : g_reg
            logic [WIDTH-1:0] dout_q;
            logic             rvalid_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dout_q   <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_en;
                    if (rd_en) begin
                        dout_q <= mem[rd_ptr];
                    end
                end
            end

            assign bus.data_out = dout_q;
            assign bus.r_valid  = rvalid_q;
        end
    endgenerate
endmodule

// File: doc/fifo_ctrl_v2.md
Name: fifo_ctrl_v2

Overview:
- Parametrised synchronous FIFO; successor to the team's basic valid/ready FIFO.
- Adds arbitrary (non-power-of-two) depth, occupancy count, programmable almost-full/almost-empty flags, selectable first-word-fall-through (FWFT) or registered-read mode, and sticky overflow/underflow error flags.
- Sits between producer and consumer stages on a single clock domain.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 3, number of entries; any integer >= 2.
- AF_TH, DEPTH-1, almost_full asserted when count >= AF_TH; legal range 1..DEPTH.
- AE_TH, 1, almost_empty asserted when count <= AE_TH; legal range 0..DEPTH-1.
- FWFT, 1, 1 = head word visible on data_out without a read; 0 = registered read with 1-cycle latency.
- CW, $clog2(DEPTH+1), count width (derived; not overridden).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- w_valid  in  1  write request.
- data_in  in  WIDTH  write data.
- r_ready  in  1  read request / pop.
- data_out  out  WIDTH  read data.
- r_valid  out  1  data_out holds a valid popped/head word.
- fifo_full  out  1  count == DEPTH.
- fifo_empty  out  1  count == 0.
- almost_full  out  1  count >= AF_TH.
- almost_empty  out  1  count <= AE_TH.
- count  out  CW  current occupancy, 0..DEPTH.
- clr_err  in  1  synchronous clear of the sticky error flags.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=rd_ptr=0, count=0, fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, r_valid=0, data_out=0. Memory contents are not reset.
- Reset asserted mid-operation discards all stored data. On the first edge after release, the FIFO behaves as empty.
- Write accept: wr_en = w_valid & !fifo_full. A write while full is dropped, memory and wr_ptr are unchanged, and overflow is set. No write-through when full, even if a read occurs in the same cycle.
- Read accept: rd_en = r_ready & !fifo_empty. A read while empty leaves pointers unchanged and sets underflow.
- Pointers advance by 1 on accept and wrap from DEPTH-1 to 0; no power-of-two assumption.
- Count update: +1 on write only, -1 on read only, unchanged when both are accepted. Flags are combinational decodes of the registered count, so they are valid in the cycle after the edge.
- Simultaneous read and write when count==1 (FWFT=1): the head is popped and the new word becomes the head on the next cycle. Count stays 1.
- FWFT=1:
  - data_out = mem[rd_ptr] combinationally; r_valid = !fifo_empty.
  - A word written at edge N is visible on data_out after edge N.
  - r_ready acts as an acknowledge of the current head.
- FWFT=0:
  - On rd_en, data_out <= mem[rd_ptr] at the edge and r_valid <= 1 for exactly one cycle.
  - Without rd_en, r_valid <= 0 and data_out holds its last value.
  - Latency is 1 clock from read accept to data.
- Error flags:
  - overflow sets on w_valid & fifo_full; underflow sets on r_ready & fifo_empty.
  - Both hold until clr_err=1 at an edge.
  - If clr_err and a new error event occur in the same cycle, the set wins.
- Ordering is strict FIFO. data_out never shows a word that was not accepted.

Test Plan:
- Reset/empty (DEPTH=3): release reset with no traffic -> fifo_empty=1, count=0, almost_empty=1, r_valid=0, overflow=underflow=0.
- Fill/overflow: write 0,1,2,3 on consecutive cycles with r_ready=0 -> count 1,2,3; fifo_full=1 after the 3rd write; word 3 dropped; overflow=1. Then read 3 words -> 0,1,2 in order and fifo_empty=1.
- Wrap-around (DEPTH=3): perform 10 writes of 0..9, each followed by a read -> all 10 values are returned in order; pointers wrap 2->0 repeatedly; count never exceeds 1.
- Simultaneous read/write: preload 0xA,0xB (count=2), then assert w_valid (0xC) and r_ready in the same cycle -> count stays 2, output 0xA; subsequent reads return 0xB, 0xC.
- FWFT=0 latency: preload 0x55; assert r_ready for 1 cycle -> data_out=0x55 with r_valid=1 exactly one cycle after the accept edge, then r_valid=0 with data_out held at 0x55.
- Error clear: read while empty -> underflow=1. Then clr_err=1 together with another empty read -> underflow stays 1. Then clr_err alone -> underflow=0.
- Thresholds (DEPTH=5, AF_TH=4, AE_TH=1): fill to 4 -> almost_full=1, fifo_full=0. Drain to 1 -> almost_empty=1.
- Mid-operation reset: with count=2, pulse reset=0 between edges -> flags return to reset values immediately, without waiting for an edge.
